// File: rtl/kyber_rom_zetas.sv
// rtl/kyber_rom_zetas.sv - Kyber NTT zeta ROM (Montgomery form, bit-reversed order); optional ROM_ZETAS_OUTREG_EN adds a 2nd output stage
module kyber_rom_zetas (
    input  logic               clk,
    input  logic               rst_n,
    input  logic        [6:0]  addr,
    output logic signed [15:0] dout
);

    // entry[i] = 2285 * 17^brv7(i) mod 3329, centered to -1664..+1664
    localparam logic signed [15:0] zetas [0:127] = '{
        -16'sd1044,  -16'sd758,  -16'sd359, -16'sd1517,  16'sd1493,  16'sd1422,   16'sd287,   16'sd202,
         -16'sd171,   16'sd622,  16'sd1577,   16'sd182,   16'sd962, -16'sd1202, -16'sd1474,  16'sd1468,
          16'sd573, -16'sd1325,   16'sd264,   16'sd383,  -16'sd829,  16'sd1458, -16'sd1602,  -16'sd130,
         -16'sd681,  16'sd1017,   16'sd732,   16'sd608, -16'sd1542,   16'sd411,  -16'sd205, -16'sd1571,
         16'sd1223,   16'sd652,  -16'sd552,  16'sd1015, -16'sd1293,  16'sd1491,  -16'sd282, -16'sd1544,
          16'sd516,    -16'sd8,  -16'sd320,  -16'sd666, -16'sd1618, -16'sd1162,   16'sd126,  16'sd1469,
         -16'sd853,   -16'sd90,  -16'sd271,   16'sd830,   16'sd107, -16'sd1421,  -16'sd247,  -16'sd951,
         -16'sd398,   16'sd961, -16'sd1508,  -16'sd725,   16'sd448, -16'sd1065,   16'sd677, -16'sd1275,
        -16'sd1103,   16'sd430,   16'sd555,   16'sd843, -16'sd1251,   16'sd871,  16'sd1550,   16'sd105,
          16'sd422,   16'sd587,   16'sd177,  -16'sd235,  -16'sd291,  -16'sd460,  16'sd1574,  16'sd1653,
         -16'sd246,   16'sd778,  16'sd1159,  -16'sd147,  -16'sd777,  16'sd1483,  -16'sd602,  16'sd1119,
        -16'sd1590,   16'sd644,  -16'sd872,   16'sd349,   16'sd418,   16'sd329,  -16'sd156,   -16'sd75,
          16'sd817,  16'sd1097,   16'sd603,   16'sd610,  16'sd1322, -16'sd1285, -16'sd1465,   16'sd384,
        -16'sd1215,  -16'sd136,  16'sd1218, -16'sd1335,  -16'sd874,   16'sd220, -16'sd1187, -16'sd1659,
        -16'sd1185, -16'sd1530, -16'sd1278,   16'sd794, -16'sd1510,  -16'sd854,  -16'sd870,   16'sd478,
         -16'sd108,  -16'sd308,   16'sd996,   16'sd991,   16'sd958, -16'sd1460,  16'sd1522,  16'sd1628
    };

    logic signed [15:0] rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= zetas[addr];
        end
    end

`ifdef ROM_ZETAS_OUTREG_EN
    // Extra retiming stage; cleared with the first so no stale value survives reset
    logic signed [15:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= rd_q;
        end
    end

    assign dout = out_q;
`else
    assign dout = rd_q;
`endif

endmodule

// File: tb/tb_kyber_rom_zetas.sv
// tb/tb_kyber_rom_zetas.sv - scoreboard bench for kyber_rom_zetas
module tb_kyber_rom_zetas;

`ifdef ROM_ZETAS_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic               clk;
    logic               rst_n;
    logic        [6:0]  addr;
    logic signed [15:0] dout;

    kyber_rom_zetas dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int exp;
        int due;
        int a;
    } sb_item_t;

    sb_item_t sb[$];
    int cyc     = 0;
    int n_pass  = 0;
    int n_check = 0;

    function automatic int golden(input int i);
        int br, p, v;
        br = 0;
        for (int k = 0; k < 7; k++) br |= ((i >> k) & 1) << (6 - k);
        p = 1;
        for (int k = 0; k < br; k++) p = (p * 17) % 3329;
        v = (2285 * p) % 3329;
        if (v > 1664) v -= 3329;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_check++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge clk) begin
        cyc++;
        #2;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            if (sb[0].due < cyc)
                check($sformatf("late_addr%0d", sb[0].a), cyc, sb[0].due);
            else
                check($sformatf("dout_addr%0d", sb[0].a), int'(dout), sb[0].exp);
            void'(sb.pop_front());
        end
    end

    task automatic drive(input int a, input int exp);
        sb_item_t it;
        @(negedge clk);
        addr = 7'(a);
        it.exp = exp;
        it.due = cyc + LAT;
        it.a   = a;
        sb.push_back(it);
    endtask

    // Called right after drive(a): pulse reset between edges, discard in-flight results
    task automatic pulse_reset(input int a, input int exp);
        sb_item_t it;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", int'(dout), 0);
        rst_n = 1'b1;
        #1;
        check("post_release_zero", int'(dout), 0);
        sb.delete();
        if (LAT == 2) begin
            it.exp = 0; it.due = cyc + 1; it.a = a;
            sb.push_back(it);
        end
        it.exp = exp; it.due = cyc + LAT; it.a = a;
        sb.push_back(it);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        sb_item_t it;
        rst_n = 1'b0;
        addr  = 7'd5;
        #1;
        check("reset_async_no_clock", int'(dout), 0);
        repeat (3) @(negedge clk);
        check("reset_held", int'(dout), 0);

        rst_n = 1'b1;
        #1;
        check("release_zero", int'(dout), 0);
        if (LAT == 2) begin
            it.exp = 0; it.due = cyc + 1; it.a = 5;
            sb.push_back(it);
        end
        it.exp = 1422; it.due = cyc + LAT; it.a = 5;
        sb.push_back(it);

        drive(0, -1044);
        drive(1, -758);
        drive(127, 1628);
        drive(64, -1103);
        drive(41, -8);
        drive(2, -359);

        for (int i = 0; i < 10; i++) drive(7, 202);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(2, -359);
            else            drive(126, 1522);
        end

        for (int i = 0; i < 128; i++) begin
            drive(i, golden(i));
            if (i == 60) pulse_reset(i, golden(i));
        end

        repeat (LAT + 2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
